// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   DATA_W                     : data path width (32).
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL : req_size encodings.
//   state_e                    : controller FSM states.
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane logic for byte-addressed accesses.
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size (SZ_*)
//   is_unsigned in  1   loads: 1 = zero-extend, 0 = sign-extend
//   wdata       in  32  right-aligned store data
//   rword       in  32  raw memory word for loads
//   byte_en     out 4   lanes to write (all zero on fault)
//   wdata_rep   out 32  store data replicated across lanes
//   fault       out 1   misaligned or illegal size
//   rdata_ext   out 32  extracted and extended load data (zero on fault)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        byte_en,
  output logic [DATA_W-1:0] wdata_rep,
  output logic              fault,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Little-endian lanes: shift the addressed byte down to bit 0.
  assign shifted  = rword >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    fault     = 1'b0;
    byte_en   = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        fault     = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        fault     = (addr_lo != 2'b00);
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: begin
        fault = 1'b1;
      end
    endcase
    // A faulting access neither writes nor returns data.
    if (fault) begin
      byte_en   = 4'b0000;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data-memory controller with valid/ready request
// handshake, configurable wait states and misalignment fault reporting.
// Parameters: ADDR_W (word-address bits), WAIT_CYC (extra wait states, 0..15).
// Ports:
//   clk, rst_n (async active-low)
//   req_valid/req_ready handshake; req_we, req_addr (byte), req_size,
//   req_unsigned, req_wdata describe the access.
//   rsp_valid one-cycle pulse with rsp_rdata / rsp_fault.
// Optional: define DMEM_TRACE_EN to print one line per committed access
// (plus words 0..7 after each store) in simulation.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              in_wait;
  logic              cur_we;
  logic [ADDR_W+1:0] cur_addr;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] cur_idx;
  logic [DATA_W-1:0] rword;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic              al_fault;
  logic [DATA_W-1:0] al_rdata;
  logic              mem_we;

  assign accept  = req_valid & req_ready_q;
  assign in_wait = (state_q == ST_WAIT);

  // With no wait states the commit edge is the accept edge itself, so the
  // live request is used; otherwise the captured copy is committed.
  assign cur_we    = in_wait ? we_q    : req_we;
  assign cur_addr  = in_wait ? addr_q  : req_addr;
  assign cur_size  = in_wait ? size_q  : req_size;
  assign cur_uns   = in_wait ? uns_q   : req_unsigned;
  assign cur_wdata = in_wait ? wdata_q : req_wdata;
  assign cur_idx   = cur_addr[ADDR_W+1:2];
  assign rword     = mem[cur_idx];

  dmem_lane_align u_align (
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .wdata       (cur_wdata),
    .rword       (rword),
    .byte_en     (al_be),
    .wdata_rep   (al_wdata),
    .fault       (al_fault),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enter_resp  = (state_d == ST_RESP);
    req_ready_d = (state_d != ST_WAIT);
    rsp_valid_d = enter_resp;
    rsp_fault_d = enter_resp & al_fault;
    rsp_rdata_d = (enter_resp && !cur_we) ? al_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // rst_n gates the write so an access seen while reset is held never commits.
  assign mem_we = rst_n & enter_resp & cur_we;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (al_be[b]) begin
          mem[cur_idx][8*b +: 8] <= al_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

`ifdef DMEM_TRACE_EN
  logic [DATA_W-1:0] trace_merged;

  always_comb begin
    trace_merged = rword;
    for (int b = 0; b < 4; b++) begin
      if (al_be[b]) begin
        trace_merged[8*b +: 8] = al_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp) begin
      $display("DMEM %s addr=%h size=%d data=%h",
               al_fault ? "F" : (cur_we ? "W" : "R"), cur_addr, cur_size,
               cur_we ? cur_wdata : al_rdata);
      if (cur_we && !al_fault) begin
        for (int i = 0; i < 8; i++) begin
          $display("DMEM   word[%0d]=%h", i,
                   (ADDR_W'(i) == cur_idx) ? trace_merged : mem[i]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized checks of dmem_ctrl with WAIT_CYC=0
// (instance 0) and WAIT_CYC=3 (instance 1) against a byte-array reference.
module tb_dmem_ctrl;

  localparam int AW   = 10;
  localparam int MEMB = 4 * (1 << AW);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [AW+1:0] req_addr   [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_fault    [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_mem [2][MEMB];

  dmem_ctrl #(.ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_fault(rsp_fault[0])
  );

  dmem_ctrl #(.ADDR_W(AW), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_fault(rsp_fault[1])
  );

  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a flat byte array; an access touches 2**size
  // consecutive bytes, loads are assembled little-endian and extended.
  function automatic void model(input int d, input bit we, input int a, input int sz,
                                input bit uns, input logic [31:0] wd,
                                output logic [31:0] rd, output bit flt);
    longint v;
    int     n;
    flt = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    rd  = 32'h0;
    if (flt) return;
    n = 1 << sz;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[d][(a + i) % MEMB] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(model_mem[d][(a + i) % MEMB]) << (8 * i));
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rd = v[31:0];
    end
  endfunction

  task automatic xact(input int d, input bit we, input int a, input int sz, input bit uns,
                      input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int          lat;
    logic [31:0] exp_rd;
    bit          exp_f;
    model(d, we, a, sz, uns, wd, exp_rd, exp_f);
    @(negedge clk);
    req_we[d]       = we;
    req_addr[d]     = (AW+2)'(a);
    req_size[d]     = 2'(sz);
    req_unsigned[d] = uns;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
    lat = 0;
    while (!req_ready[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("ready_timeout", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request after accept; the controller must use its copy.
    req_valid[d]    = 1'b0;
    req_we[d]       = 1'($urandom);
    req_addr[d]     = (AW+2)'($urandom);
    req_size[d]     = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    req_wdata[d]    = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 40);
    rd  = rsp_rdata[d];
    flt = rsp_fault[d];
    check("latency", 32'(lat), 32'(wait_of(d) + 1));
    check("rdata", rd, exp_rd);
    check("fault", 32'(flt), 32'(exp_f));
    $display("[TB] dut%0d %s a=%h sz=%0d u=%0d wd=%h -> rd=%h flt=%0d lat=%0d",
             d, we ? "ST" : "LD", a, sz, uns, wd, rd, flt, lat);
  endtask

  initial begin
    logic [31:0] rd, exp_rd, exp_rd2;
    logic        flt;
    bit          ef;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = 2'b00; req_unsigned[d] = 1'b0; req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rdata", rsp_rdata[d], 32'd0);
      check("rst_fault", 32'(rsp_fault[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Give every word that will be read a known value.
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 'h140; a += 4) xact(d, 1, a, 2, 0, $urandom, rd, flt);

    // Word store then load, no wait states.
    xact(0, 1, 'h10, 2, 0, 32'hDEADBEEF, rd, flt);
    xact(0, 0, 'h10, 2, 0, 32'h0, rd, flt);
    check("t1_rdata", rd, 32'hDEADBEEF);

    // Sub-word store and extended loads.
    xact(0, 1, 'h12, 0, 0, 32'h0000005A, rd, flt);
    xact(0, 0, 'h10, 2, 0, 32'h0, rd, flt);
    check("t2_word", rd, 32'hDE5ABEEF);
    xact(0, 0, 'h13, 0, 0, 32'h0, rd, flt);
    check("t2_byte_s", rd, 32'hFFFFFFDE);
    xact(0, 0, 'h13, 0, 1, 32'h0, rd, flt);
    check("t2_byte_u", rd, 32'h000000DE);
    xact(0, 0, 'h12, 1, 0, 32'h0, rd, flt);
    check("t2_half_s", rd, 32'hFFFFDE5A);

    // Misaligned and illegal accesses.
    xact(0, 1, 'h20, 2, 0, 32'hCAFEF00D, rd, flt);
    xact(0, 1, 'h22, 2, 0, 32'h12345678, rd, flt);
    check("t4_st_fault", 32'(flt), 32'd1);
    check("t4_st_rdata", rd, 32'd0);
    xact(0, 0, 'h20, 2, 0, 32'h0, rd, flt);
    check("t4_unchanged", rd, 32'hCAFEF00D);
    xact(0, 0, 'h21, 1, 0, 32'h0, rd, flt);
    check("t4_half_fault", 32'(flt), 32'd1);
    xact(0, 0, 'h20, 3, 0, 32'h0, rd, flt);
    check("t4_ill_fault", 32'(flt), 32'd1);

    // Back-to-back store then load of the same word.
    model(0, 1, 'h40, 2, 0, 32'h11223344, exp_rd, ef);
    model(0, 0, 'h40, 2, 0, 32'h0, exp_rd, ef);
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0] = 'h40; req_size[0] = 2'b10;
    req_unsigned[0] = 1'b0; req_wdata[0] = 32'h11223344; req_valid[0] = 1'b1;
    @(negedge clk);
    check("t5_st_valid", 32'(rsp_valid[0]), 32'd1);
    check("t5_st_fault", 32'(rsp_fault[0]), 32'd0);
    req_we[0] = 1'b0; req_wdata[0] = 32'h0;
    @(negedge clk);
    check("t5_ld_valid", 32'(rsp_valid[0]), 32'd1);
    check("t5_ld_rdata", rsp_rdata[0], 32'h11223344);
    check("t5_ld_model", rsp_rdata[0], exp_rd);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_idle", 32'(rsp_valid[0]), 32'd0);

    // Wait states with req_valid held high across the access.
    model(1, 0, 'h30, 2, 0, 32'h0, exp_rd2, ef);
    @(negedge clk);
    req_we[1] = 1'b0; req_addr[1] = 'h30; req_size[1] = 2'b10;
    req_unsigned[1] = 1'b0; req_valid[1] = 1'b1;
    check("t3_ready_idle", 32'(req_ready[1]), 32'd1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("t3_ready_low", 32'(req_ready[1]), 32'd0);
        check("t3_no_rsp", 32'(rsp_valid[1]), 32'd0);
      end
      @(negedge clk);
      check("t3_rsp", 32'(rsp_valid[1]), 32'd1);
      check("t3_rdata", rsp_rdata[1], exp_rd2);
      check("t3_ready_resp", 32'(req_ready[1]), 32'd1);
      if (pass == 1) req_valid[1] = 1'b0;
    end
    @(negedge clk);
    check("t3_pulse", 32'(rsp_valid[1]), 32'd0);

    // Reset during the wait phase of a store aborts it.
    xact(1, 1, 'h50, 2, 0, 32'h0A0B0C0D, rd, flt);
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 'h50; req_size[1] = 2'b10;
    req_wdata[1] = 32'h99999999; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(req_ready[1]), 32'd1);
    check("t6_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("t6_rdata", rsp_rdata[1], 32'd0);
    check("t6_fault", 32'(rsp_fault[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1, 0, 'h50, 2, 0, 32'h0, rd, flt);
    check("t6_old", rd, 32'h0A0B0C0D);

    // Randomized traffic over a prefilled window on both instances.
    for (int i = 0; i < 200; i++) begin
      xact(int'($urandom_range(0, 1)), 1'($urandom), 'h100 + int'($urandom_range(0, 63)),
           int'($urandom_range(0, 3)), 1'($urandom), $urandom, rd, flt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the pipelined core's MEM stage, the next generation of the flat word-addressed data RAM. It adds byte addressing, byte/half/word stores with lane enables, and sign/zero-extended sub-word loads. It also adds a valid/ready request handshake, a configurable wait-state counter that models slower memory, and misalignment fault reporting. The pipeline stalls MEM on req_ready low and consumes results on rsp_valid.

Parameters:
ADDR_W, 10, word-address bits; depth = 2**ADDR_W words of 32 bits.
WAIT_CYC, 0, extra wait states per access, legal range 0..15.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W+2  byte address.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  one-cycle pulse; the response is complete.
rsp_rdata  out  32  extended load data; 0 for stores and faults.
rsp_fault  out  1  qualified by rsp_valid; the access was misaligned or illegal.

Behaviour:
- Reset: state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Memory contents are not reset.
  - Reset asserted mid-access aborts it; a pending store is not committed.
- Handshake:
  - Accept = req_valid & req_ready.
  - The controller captures req_* into holding registers on the accept edge.
  - After accept, req_* may change freely.
- FSM: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, go to WAIT if WAIT_CYC>0 (counter loaded with WAIT_CYC-1), else RESP.
  - WAIT: req_ready=0. Counter decrements; at 0, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=1.
    - On accept, reload as from IDLE.
    - Otherwise return to IDLE.
- Latency: rsp_valid rises WAIT_CYC+1 cycles after the accept edge. With WAIT_CYC=0, back-to-back accepts give one response per cycle.
- Commit: the array write and the load-data capture both occur on the edge that enters RESP.
  - A load issued right after a store to the same word returns the new data.
- Word index = addr[ADDR_W+1:2]. Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
- Store: write only the selected lanes; other bytes are unchanged.
  - Byte: wdata[7:0] is replicated to the lane.
  - Half: wdata[15:0] is written to the lane.
- Load: extract the lane, then extend it to 32 bits per req_unsigned. A word load ignores req_unsigned.
- Fault conditions: size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - On fault: no write, rsp_rdata=0, rsp_fault=1, same latency as a normal access.
- The address wraps modulo the depth; high address bits do not exist beyond ADDR_W+2.

Optional Feature:
DMEM_TRACE_EN. When defined, the module prints one $display line per committed access on the RESP entry edge.
- Format: "DMEM W|R|F addr=%h size=%d data=%h".
- It also prints words 0..7 after each store.

When the macro is undefined, there is no simulation output and no functional difference.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - the FSM state typedef;
  - the constant DATA_W=32.
- One sub-module, dmem_lane_align, is combinational. It produces byte-enables, write-data replication, fault detection and load extract/extend, and is tested standalone.
- The FSM, counter and array live in dmem_ctrl.

Test Plan:
1. Reset, WAIT_CYC=0: store word 0xDEADBEEF at byte address 0x10, then load word 0x10. rsp_valid arrives 1 cycle after each accept; rdata=0xDEADBEEF; fault=0.
2. Starting from word 0xDEADBEEF at 0x10:
   - store byte 0x5A to 0x12; load word 0x10 gives 0xDE5ABEEF;
   - load byte signed 0x13 gives 0xFFFFFFDE;
   - load byte unsigned 0x13 gives 0x000000DE;
   - load half signed 0x12 gives 0xFFFFDE5A.
3. WAIT_CYC=3: one accepted load gives req_ready=0 for 3 cycles and rsp_valid 4 cycles after accept.
   - req_valid held high is not accepted again until RESP.
4. Misaligned access: word store to 0x22 gives fault=1, rdata=0. A following load word 0x20 returns the old value unchanged.
   - half load 0x21 gives fault=1.
   - size=11 gives fault=1.
5. Back-to-back accesses, WAIT_CYC=0: store 0x11223344 @0x40 accepted on cycle N, load 0x40 accepted on cycle N+1. The load's response on N+2 gives 0x11223344.
6. Reset asserted during WAIT of a store to 0x50: outputs return to reset values; a later load of 0x50 shows the prior contents.
